traffic_light_monitor: RTL and testbench

Passive checker on the receiving end of the 2-bit traffic light code bus (00=Red, 01=Green, 10=Yellow, 11=invalid). It samples the light code every clock, tracks the expected Red->Green->Yellow->Red sequence and per-state dwell times, and reports sticky error flags, a one-cycle error pulse and a completed-cycle count. It sits beside the light controller output, feeding status/interrupt logic and simulation assertions.

---
 rtl/traffic_light_monitor.sv | 189 ++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
//
// Passive checker on the receive side of a 2-bit traffic light code bus
// (00=Red, 01=Green, 10=Yellow, 11=invalid). The light code is sampled on every
// enabled clock edge. The monitor follows the Red->Green->Yellow->Red order,
// measures how long each colour is held, and reports what it finds.
//
// Ports
//   clk          in   clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   enable       in   1 = monitor active, 0 = hold state (err_pulse forced low)
//   light        in   [1:0] observed light code
//   clear_err    in   synchronous clear of err_flags (set wins on same edge)
//   err_flags    out  [3:0] sticky: [0] illegal sequence, [1] dwell too short,
//                     [2] stuck, [3] invalid code 11
//   err_pulse    out  one-cycle pulse on any edge with a new detection
//   cycle_count  out  [7:0] completed legal Yellow->Red transitions (wraps)
//   tracking     out  1 while the FSM is in TRACK
//
// All outputs are registered. Detections become visible one cycle after the
// offending code is sampled.
//
// FSM states
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_ACQUIRE | waiting for the first Red; no sequence or dwell checks
//   ST_TRACK   | locked to the sequence; order, dwell and stuck checks run
// -----------------------------------------------------------------------------
module traffic_light_monitor #(
  parameter int MIN_RED    = 1,
  parameter int MIN_GREEN  = 1,
  parameter int MIN_YELLOW = 1,
  parameter int MAX_DWELL  = 8,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] light,
  input  logic       clear_err,
  output logic [3:0] err_flags,
  output logic       err_pulse,
  output logic [7:0] cycle_count,
  output logic       tracking
);

  localparam logic [0:0] ST_ACQUIRE = 1'b0;
  localparam logic [0:0] ST_TRACK   = 1'b1;

  localparam logic [1:0] L_RED    = 2'b00;
  localparam logic [1:0] L_GREEN  = 2'b01;
  localparam logic [1:0] L_YELLOW = 2'b10;
  localparam logic [1:0] L_BAD    = 2'b11;

  // Error bit positions
  localparam int E_SEQ   = 0;
  localparam int E_SHORT = 1;
  localparam int E_STUCK = 2;
  localparam int E_CODE  = 3;

  // Comparisons are done one bit wider than the dwell counter so that a
  // saturated counter (all ones) plus one can never alias a threshold.
  localparam logic [CNT_W-1:0] DWELL_SAT   = '1;
  localparam logic [CNT_W:0]   MIN_RED_C   = (CNT_W+1)'(MIN_RED);
  localparam logic [CNT_W:0]   MIN_GREEN_C = (CNT_W+1)'(MIN_GREEN);
  localparam logic [CNT_W:0]   MIN_YEL_C   = (CNT_W+1)'(MIN_YELLOW);
  localparam logic [CNT_W:0]   MAX_DWELL_C = (CNT_W+1)'(MAX_DWELL);
  localparam logic             STUCK_EN    = (MAX_DWELL != 0);

  logic [0:0]       state_q,      state_d;
  logic [1:0]       last_light_q, last_light_d;
  logic [CNT_W-1:0] dwell_q,      dwell_d;
  logic [3:0]       err_flags_q,  err_flags_d;
  logic             err_pulse_q,  err_pulse_d;
  logic [7:0]       cycle_cnt_q,  cycle_cnt_d;
  logic             tracking_q,   tracking_d;

  logic             changed;
  logic             legal_pair;
  logic [CNT_W:0]   dwell_ext;
  logic [CNT_W:0]   dwell_inc;
  logic [CNT_W:0]   min_old;
  logic [3:0]       det;

  assign changed   = (light != last_light_q);
  assign dwell_ext = {1'b0, dwell_q};
  assign dwell_inc = dwell_ext + (CNT_W+1)'(1);

  // The only legal successors are Red->Green, Green->Yellow, Yellow->Red.
  always_comb begin
    legal_pair = 1'b0;
    min_old    = MIN_RED_C;
    unique case (last_light_q)
      L_RED: begin
        legal_pair = (light == L_GREEN);
        min_old    = MIN_RED_C;
      end
      L_GREEN: begin
        legal_pair = (light == L_YELLOW);
        min_old    = MIN_GREEN_C;
      end
      L_YELLOW: begin
        legal_pair = (light == L_RED);
        min_old    = MIN_YEL_C;
      end
      default: begin
        legal_pair = 1'b0;
        min_old    = MIN_RED_C;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_light_d = last_light_q;
    dwell_d      = dwell_q;
    cycle_cnt_d  = cycle_cnt_q;
    det          = '0;

    if (enable) begin
      last_light_d = light;
      if (changed) begin
        dwell_d = CNT_W'(1);
      end else if (dwell_q != DWELL_SAT) begin
        dwell_d = dwell_q + CNT_W'(1);
      end

      unique case (state_q)
        ST_ACQUIRE: begin
          if (light == L_BAD) begin
            det[E_CODE] = 1'b1;
          end else if (light == L_RED) begin
            state_d = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (light == L_BAD) begin
            // Invalid code drops lock; order and dwell are not judged here.
            det[E_CODE] = 1'b1;
            state_d     = ST_ACQUIRE;
          end else if (changed) begin
            det[E_SEQ]   = !legal_pair;
            det[E_SHORT] = (dwell_ext < min_old);
            if (legal_pair && (last_light_q == L_YELLOW)) begin
              cycle_cnt_d = cycle_cnt_q + 8'd1;
            end
          end else if (STUCK_EN && (dwell_inc == MAX_DWELL_C)) begin
            // Fires once: the counter passes the threshold and saturates
            // above it until the light changes.
            det[E_STUCK] = 1'b1;
          end
        end
        default: state_d = ST_ACQUIRE;
      endcase
    end

    // Newly detected bits survive a simultaneous clear.
    err_flags_d = (clear_err ? 4'b0000 : err_flags_q) | det;
    err_pulse_d = |det;
    tracking_d  = (state_d == ST_TRACK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_ACQUIRE;
      last_light_q <= L_RED;
      dwell_q      <= '0;
      err_flags_q  <= '0;
      err_pulse_q  <= 1'b0;
      cycle_cnt_q  <= '0;
      tracking_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_light_q <= last_light_d;
      dwell_q      <= dwell_d;
      err_flags_q  <= err_flags_d;
      err_pulse_q  <= err_pulse_d;
      cycle_cnt_q  <= cycle_cnt_d;
      tracking_q   <= tracking_d;
    end
  end

  assign err_flags   = err_flags_q;
  assign err_pulse   = err_pulse_q;
  assign cycle_count = cycle_cnt_q;
  assign tracking    = tracking_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor. Two instances share the stimulus: one with
// default parameters and one with tighter minimum dwells and a short stuck
// limit. Each has its own behavioural reference model.
module tb_traffic_light_monitor;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic [1:0] light;
  logic       clear_err;

  logic [3:0] flags0, flags1;
  logic       pulse0, pulse1;
  logic [7:0] cnt0, cnt1;
  logic       trk0, trk1;

  int checks = 0;
  int errors = 0;

  traffic_light_monitor u_dut_def (
    .clk(clk), .reset_n(reset_n), .enable(enable), .light(light),
    .clear_err(clear_err), .err_flags(flags0), .err_pulse(pulse0),
    .cycle_count(cnt0), .tracking(trk0)
  );

  traffic_light_monitor #(
    .MIN_RED(2), .MIN_GREEN(3), .MIN_YELLOW(2), .MAX_DWELL(5), .CNT_W(4)
  ) u_dut_alt (
    .clk(clk), .reset_n(reset_n), .enable(enable), .light(light),
    .clear_err(clear_err), .err_flags(flags1), .err_pulse(pulse1),
    .cycle_count(cnt1), .tracking(trk1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         p_min[2][3];
  int         p_max[2];
  bit         m_trk[2];
  logic [1:0] m_prev[2];
  int         m_run[2];
  logic [3:0] m_flags[2];
  bit         m_pulse[2];
  int         m_cnt[2];

  function automatic logic [1:0] succ(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_trk[k] = 0; m_prev[k] = 2'd0; m_run[k] = 0;
      m_flags[k] = 4'h0; m_pulse[k] = 0; m_cnt[k] = 0;
    end
  endfunction

  function automatic void model_step(input logic en, input logic [1:0] l, input logic clr);
    for (int k = 0; k < 2; k++) begin
      logic [3:0] nd;
      bit ch;
      nd = 4'h0;
      if (en) begin
        ch = (l != m_prev[k]);
        if (l == 2'd3) begin
          nd[3] = 1'b1;
          m_trk[k] = 0;
        end else if (!m_trk[k]) begin
          if (l == 2'd0) m_trk[k] = 1;
        end else if (ch) begin
          if (l != succ(m_prev[k])) nd[0] = 1'b1;
          if (m_run[k] < p_min[k][m_prev[k]]) nd[1] = 1'b1;
          if (l == succ(m_prev[k]) && m_prev[k] == 2'd2) m_cnt[k] = (m_cnt[k] + 1) % 256;
        end else if (p_max[k] != 0 && m_run[k] + 1 == p_max[k]) begin
          nd[2] = 1'b1;
        end
        m_run[k]  = ch ? 1 : m_run[k] + 1;
        m_prev[k] = l;
      end
      m_flags[k] = (clr ? 4'h0 : m_flags[k]) | nd;
      m_pulse[k] = (nd != 4'h0);
    end
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s def flags", tag), int'(flags0), int'(m_flags[0]));
    chk($sformatf("%s def pulse", tag), int'(pulse0), int'(m_pulse[0]));
    chk($sformatf("%s def count", tag), int'(cnt0),   m_cnt[0]);
    chk($sformatf("%s def track", tag), int'(trk0),   int'(m_trk[0]));
    chk($sformatf("%s alt flags", tag), int'(flags1), int'(m_flags[1]));
    chk($sformatf("%s alt pulse", tag), int'(pulse1), int'(m_pulse[1]));
    chk($sformatf("%s alt count", tag), int'(cnt1),   m_cnt[1]);
    chk($sformatf("%s alt track", tag), int'(trk1),   int'(m_trk[1]));
  endtask

  task automatic drive(input logic [1:0] l, input logic en = 1'b1, input logic clr = 1'b0,
                       input string tag = "dir");
    light = l; enable = en; clear_err = clr;
    @(posedge clk);
    model_step(en, l, clr);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2;
    reset_n = 1'b1;
  endtask

  task automatic drive_seq(input logic [1:0] l, input int n, input string tag);
    for (int i = 0; i < n; i++) drive(l, 1'b1, 1'b0, tag);
  endtask

  int pulse_seen;

  initial begin
    p_min[0] = '{1, 1, 1}; p_max[0] = 8;
    p_min[1] = '{2, 3, 2}; p_max[1] = 5;
    reset_n = 1'b0; enable = 1'b0; light = 2'd0; clear_err = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_all("reset");
    reset_n = 1'b1;

    // Three clean loops, closing the third Yellow->Red.
    pulse_seen = 0;
    for (int i = 0; i < 3; i++) begin
      drive(2'd0); pulse_seen += int'(pulse0);
      drive(2'd1); pulse_seen += int'(pulse0);
      drive(2'd2); pulse_seen += int'(pulse0);
    end
    drive(2'd0); pulse_seen += int'(pulse0);
    chk("loops count", int'(cnt0), 3);
    chk("loops flags", int'(flags0), 0);
    chk("loops pulses", pulse_seen, 0);

    // Illegal Green->Red.
    drive(2'd1);
    drive(2'd0, 1'b1, 1'b0, "illegal");
    chk("illegal flag0", int'(flags0[0]), 1);
    chk("illegal pulse", int'(pulse0), 1);
    chk("illegal count", int'(cnt0), 3);
    drive(2'd0, 1'b1, 1'b1, "clear");
    chk("clear flags", int'(flags0), 0);

    // Short and adequate green on the alt instance.
    drive_seq(2'd0, 2, "g"); drive_seq(2'd1, 2, "g"); drive(2'd2, 1'b1, 1'b0, "gshort");
    chk("green short alt", int'(flags1[1]), 1);
    drive(2'd2, 1'b1, 1'b1, "gclr");
    drive_seq(2'd0, 2, "g"); drive_seq(2'd1, 3, "g"); drive(2'd2, 1'b1, 1'b0, "gok");
    chk("green ok alt", int'(flags1[1]), 0);

    // Stuck green.
    drive_seq(2'd0, 2, "s");
    pulse_seen = 0;
    for (int i = 0; i < 12; i++) begin
      drive(2'd1, 1'b1, 1'b0, "stuck");
      pulse_seen += int'(pulse0);
      if (i == 7) chk("stuck flag2", int'(flags0[2]), 1);
    end
    chk("stuck pulses", pulse_seen, 1);

    // Invalid code while tracking, then resync.
    drive(2'd3, 1'b1, 1'b0, "bad");
    chk("bad flag3", int'(flags0[3]), 1);
    chk("bad track", int'(trk0), 0);
    drive(2'd1, 1'b1, 1'b1, "acq"); drive(2'd2, 1'b1, 1'b0, "acq");
    chk("acq no flag0", int'(flags0[0]), 0);
    drive(2'd0, 1'b1, 1'b0, "resync");
    chk("resync track", int'(trk0), 1);

    // Clear coinciding with a detection: set wins.
    drive(2'd1); drive(2'd3); drive(2'd0); drive(2'd1);
    drive(2'd0, 1'b1, 1'b1, "setwins");
    chk("setwins flags", int'(flags0), 1);
    drive(2'd0, 1'b1, 1'b1, "clronly");
    chk("clronly flags", int'(flags0), 0);

    // Enable low holds state.
    drive(2'd1, 1'b0, 1'b0, "hold"); drive(2'd3, 1'b0, 1'b0, "hold");

    // Async reset mid-sequence.
    drive(2'd1); drive(2'd2); drive(2'd0);
    do_reset("midreset");
    chk("midreset count", int'(cnt0), 0);

    // Randomized phase.
    begin
      logic [1:0] cur;
      cur = 2'd0;
      for (int n = 0; n < 4000; n++) begin
        int r;
        logic [1:0] nl;
        r = $urandom_range(0, 99);
        if (r < 60)      nl = succ(cur == 2'd3 ? 2'd2 : cur);
        else if (r < 85) nl = cur;
        else if (r < 94) nl = 2'($urandom_range(0, 2));
        else             nl = 2'd3;
        if ($urandom_range(0, 599) == 0) do_reset("rnd reset");
        drive(nl, ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0), "rnd");
        cur = nl;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
